// File: rtl/vga_timing_640x480.sv
// VGA raster timing for 640x480@60 (25 MHz pixel rate via pix_stb on CLK100MHZ).
// Define VGA_FRAME_COUNTER_EN to add the 8-bit frame_cnt output.
module vga_timing_640x480 #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       pix_stb,
  output logic       hs,
  output logic       vs,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_end,
  output logic       frame_end
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);

  logic x_last;
  logic y_last;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      x         <= '0;
      y         <= '0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= pix_stb && x_last;
      frame_end <= pix_stb && x_last && y_last;
      if (pix_stb) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      frame_cnt <= '0;
    end else if (pix_stb && x_last && y_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

  // Sync/blank decode looks only at the registered counters; RST overrides to idle levels.
  assign hs     = RST | ~((x >= HS_START) && (x < HS_END));
  assign vs     = RST | ~((y >= VS_START) && (y < VS_END));
  assign active = ~RST & (x < X_VIS) & (y < Y_VIS);

endmodule

// File: tb/tb_vga_timing_640x480.sv
// Scoreboard bench for vga_timing_640x480: full-size instance for line timing,
// a shrunken-raster instance so whole frames fit a short run.
module tb_vga_timing_640x480;

  localparam int SH_A = 6, SH_F = 1, SH_S = 2, SH_B = 1;
  localparam int SV_A = 4, SV_F = 1, SV_S = 2, SV_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m = 1'b0, stb_m = 1'b0, rst_s = 1'b0, stb_s = 1'b0;
  logic hs_m, vs_m, act_m, le_m, fe_m;
  logic hs_s, vs_s, act_s, le_s, fe_s;
  logic [9:0] x_m, y_m, x_s, y_s;
`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] fc_m, fc_s;
`endif

  vga_timing_640x480 u_dut (
    .CLK100MHZ(clk), .RST(rst_m), .pix_stb(stb_m),
    .hs(hs_m), .vs(vs_m), .active(act_m), .x(x_m), .y(y_m),
    .line_end(le_m), .frame_end(fe_m)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_m)
`endif
  );

  vga_timing_640x480 #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
  ) u_dut_small (
    .CLK100MHZ(clk), .RST(rst_s), .pix_stb(stb_s),
    .hs(hs_s), .vs(vs_s), .active(act_s), .x(x_s), .y(y_s),
    .line_end(le_s), .frame_end(fe_s)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_cnt(fc_s)
`endif
  );

  typedef struct {
    int x; int y; int hs; int vs; int act; int le; int fe; int fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   p_m = 0, p_s = 0, fc_m_e = 0, fc_s_e = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus on the selected instance; the other instance idles.
  task automatic step(input bit sel, input bit stb, input bit rst);
    int ha, hf, hw, va, vf, vw, ht, vt, p, fc;
    exp_t e;
    if (!sel) begin
      ha = 640; hf = 16; hw = 96; ht = 800;
      va = 480; vf = 10; vw = 2;  vt = 525;
      p = p_m; fc = fc_m_e;
    end else begin
      ha = SH_A; hf = SH_F; hw = SH_S; ht = SH_A + SH_F + SH_S + SH_B;
      va = SV_A; vf = SV_F; vw = SV_S; vt = SV_A + SV_F + SV_S + SV_B;
      p = p_s; fc = fc_s_e;
    end
    e.le = 0;
    e.fe = 0;
    if (rst) begin
      p  = 0;
      fc = 0;
    end else if (stb) begin
      e.le = ((p % ht) == ht - 1) ? 1 : 0;
      e.fe = (e.le == 1 && (p / ht) == vt - 1) ? 1 : 0;
      p    = (p + 1) % (ht * vt);
      if (e.fe == 1) fc = (fc + 1) % 256;
    end
    e.x   = p % ht;
    e.y   = p / ht;
    e.hs  = (rst || !(e.x >= ha + hf && e.x < ha + hf + hw)) ? 1 : 0;
    e.vs  = (rst || !(e.y >= va + vf && e.y < va + vf + vw)) ? 1 : 0;
    e.act = (!rst && e.x < ha && e.y < va) ? 1 : 0;
    e.fc  = fc;
    if (!sel) begin
      p_m = p; fc_m_e = fc;
      stb_m = stb; rst_m = rst; stb_s = 1'b0; rst_s = 1'b0;
    end else begin
      p_s = p; fc_s_e = fc;
      stb_s = stb; rst_s = rst; stb_m = 1'b0; rst_m = 1'b0;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (!sel) begin
      check_eq("x",         int'(x_m),  e.x);
      check_eq("y",         int'(y_m),  e.y);
      check_eq("hs",        int'(hs_m), e.hs);
      check_eq("vs",        int'(vs_m), e.vs);
      check_eq("active",    int'(act_m), e.act);
      check_eq("line_end",  int'(le_m), e.le);
      check_eq("frame_end", int'(fe_m), e.fe);
`ifdef VGA_FRAME_COUNTER_EN
      check_eq("frame_cnt", int'(fc_m), e.fc);
`endif
    end else begin
      check_eq("s_x",         int'(x_s),  e.x);
      check_eq("s_y",         int'(y_s),  e.y);
      check_eq("s_hs",        int'(hs_s), e.hs);
      check_eq("s_vs",        int'(vs_s), e.vs);
      check_eq("s_active",    int'(act_s), e.act);
      check_eq("s_line_end",  int'(le_s), e.le);
      check_eq("s_frame_end", int'(fe_s), e.fe);
`ifdef VGA_FRAME_COUNTER_EN
      check_eq("s_frame_cnt", int'(fc_s), e.fc);
`endif
    end
  endtask

  initial begin
    int le_cnt, le_at, fall_x, rise_x, low, pulses, vs_low, fe_cnt;
    bit prev_hs;

    step(0, 0, 1);
    step(0, 1, 1);
    check_eq("rst_x", int'(x_m), 0);
    check_eq("rst_hs", int'(hs_m), 1);
    check_eq("rst_active", int'(act_m), 0);

    // 800 strobes, one every 4th cycle
    le_cnt = 0; le_at = -1;
    for (int i = 1; i <= 800; i++) begin
      step(0, 1, 0);
      if (le_m) begin le_cnt++; le_at = i; end
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 0);
        if (le_m) le_cnt++;
      end
    end
    check_eq("line_end_count", le_cnt, 1);
    check_eq("line_end_strobe", le_at, 800);
    check_eq("line_wrap_x", int'(x_m), 0);
    check_eq("line_wrap_y", int'(y_m), 1);

    // hsync window on back-to-back strobes
    fall_x = -1; rise_x = -1; low = 0; prev_hs = hs_m;
    for (int i = 0; i < 800 && rise_x < 0; i++) begin
      step(0, 1, 0);
      if (prev_hs && !hs_m) fall_x = int'(x_m);
      if (!prev_hs && hs_m) rise_x = int'(x_m);
      if (!hs_m) low++;
      prev_hs = hs_m;
    end
    check_eq("hs_fall_x", fall_x, 656);
    check_eq("hs_rise_x", rise_x, 752);
    check_eq("hs_low_strobes", low, 96);

    // hold with pix_stb low at x=300
    for (int i = 0; i < 1000 && x_m != 10'd300; i++) step(0, 1, 0);
    check_eq("reach_x300", int'(x_m), 300);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      if (le_m || fe_m) pulses++;
    end
    check_eq("hold_x", int'(x_m), 300);
    check_eq("hold_y", int'(y_m), 2);
    check_eq("hold_hs", int'(hs_m), 1);
    check_eq("hold_vs", int'(vs_m), 1);
    check_eq("hold_active", int'(act_m), 1);
    check_eq("hold_pulses", pulses, 0);

    for (int i = 0; i < 3000; i++) step(0, bit'($urandom_range(0, 1)), 0);

    // mid-line reset on the full-size raster
    for (int i = 0; i < 1600 && x_m != 10'd700; i++) step(0, 1, 0);
    check_eq("reach_x700", int'(x_m), 700);
    step(0, 1, 1);
    step(0, 0, 0);
    check_eq("post_rst_x", int'(x_m), 0);
    check_eq("post_rst_y", int'(y_m), 0);
    check_eq("post_rst_hs", int'(hs_m), 1);
    step(0, 1, 0);
    check_eq("first_stb_x", int'(x_m), 1);

    // whole frame on the small raster: vsync lines 5..6, one frame_end
    step(1, 0, 1);
    vs_low = 0; fe_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 0);
      if (!vs_s) begin
        vs_low++;
        check_eq("vs_line_in_window", (y_s == 10'd5 || y_s == 10'd6) ? 1 : 0, 1);
      end
      if (fe_s) fe_cnt++;
    end
    check_eq("vs_low_strobes", vs_low, 20);
    check_eq("frame_end_count", fe_cnt, 1);
    check_eq("frame_wrap_x", int'(x_s), 0);
    check_eq("frame_wrap_y", int'(y_s), 0);

    // reset inside the back porch on the last vsync line
    for (int i = 0; i < 80 && !(x_s == 10'd9 && y_s == 10'd6); i++) step(1, 1, 0);
    check_eq("reach_x9_y6", (x_s == 10'd9 && y_s == 10'd6) ? 1 : 0, 1);
    step(1, 1, 1);
    step(1, 0, 0);
    check_eq("s_post_rst_x", int'(x_s), 0);
    check_eq("s_post_rst_y", int'(y_s), 0);
    check_eq("s_post_rst_vs", int'(vs_s), 1);
    check_eq("s_post_rst_pulses", int'(le_s) + int'(fe_s), 0);
    step(1, 1, 0);
    check_eq("s_first_stb_x", int'(x_s), 1);

`ifdef VGA_FRAME_COUNTER_EN
    step(1, 0, 1);
    for (int i = 0; i < 257 * 80; i++) step(1, 1, 0);
    check_eq("frame_cnt_wrap", int'(fc_s), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
